// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment frame scanner: FSM encoding, frame layout
// and the active-low hex segment table.
package seg7_pkg;

    typedef enum logic [2:0] {
        ST_BUILD     = 3'd0,
        ST_ISSUE     = 3'd1,
        ST_WAIT_ACK  = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_DWELL     = 3'd4
    } state_e;

    localparam int SEG_MSB = 15;
    localparam int SEG_LSB = 8;
    localparam int SEL_MSB = 7;
    localparam int SEL_LSB = 0;

    localparam logic [6:0]  SEG_BLANK   = 7'h7F;
    localparam logic [15:0] FRAME_RESET = 16'hFF00;

    // Active-low {g,f,e,d,c,b,a}; leftmost entry is nibble F, rightmost is nibble 0.
    localparam logic [15:0][6:0] HEX_SEG_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    function automatic logic [7:0] digit_onehot(input logic [2:0] idx);
        digit_onehot = 8'h01 << idx;
    endfunction

endpackage

// File: rtl/seg7_hex_decoder.sv
// Combinational nibble to active-low 7-segment pattern lookup.
module seg7_hex_decoder
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    // Table lookup of the segment pattern for one hex digit.
    always_comb begin
        seg = HEX_SEG_TABLE[nibble];
    end

endmodule

// File: rtl/seg7_frame_scanner.sv
// Multiplexed 7-segment scanner producing 16-bit frames for a 74HC595 shifter.
// Optional leading-zero blanking is enabled by defining SEG7_LZ_BLANK_EN.
module seg7_frame_scanner
    import seg7_pkg::*;
#(
    parameter int DIGITS      = 4,
    parameter int REFRESH_CNT = 100000,
    parameter int ACK_TIMEOUT = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp_mask,
    input  logic                  busy,
    output logic                  start,
    output logic [15:0]           frame,
    output logic [2:0]            digit_idx,
    output logic                  scan_wrap
);

    localparam int VW = 4 * DIGITS;
    localparam int TW = (REFRESH_CNT > 2) ? $clog2(REFRESH_CNT) : 1;
    localparam int AW = $clog2(ACK_TIMEOUT) + 1;
    localparam logic [7:0] SEL_MASK = 8'((1 << DIGITS) - 1);

    state_e          state_q, state_d;
    logic [2:0]      digit_idx_q, digit_idx_d;
    logic [VW-1:0]   snap_value_q, snap_value_d;
    logic [DIGITS-1:0] snap_dp_q, snap_dp_d;
    logic [15:0]     frame_q, frame_d;
    logic            start_q, start_d;
    logic            scan_wrap_q, scan_wrap_d;
    logic [TW-1:0]   tick_cnt_q, tick_cnt_d;
    logic            tick_pending_q, tick_pending_d;
    logic [AW-1:0]   ack_cnt_q, ack_cnt_d;

    logic            tick_s;
    logic [VW-1:0]   src_value_s;
    logic [DIGITS-1:0] src_dp_s;
    logic [3:0]      nibble_s;
    logic            dp_s;
    logic [6:0]      hex_seg_s;
    logic [6:0]      seg_s;
    logic [7:0]      sel_s;
    logic [15:0]     frame_build_s;

    // Free-running refresh counter; its terminal count marks a digit tick.
    always_comb begin
        tick_s     = (tick_cnt_q == TW'(REFRESH_CNT - 1));
        tick_cnt_d = tick_s ? '0 : tick_cnt_q + TW'(1);
    end

    // Digit 0 builds from the live inputs, which are the data being captured.
    always_comb begin
        src_value_s = (digit_idx_q == 3'd0) ? value : snap_value_q;
        src_dp_s    = (digit_idx_q == 3'd0) ? dp_mask : snap_dp_q;
        nibble_s    = 4'h0;
        dp_s        = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            nibble_s = nibble_s | (src_value_s[4*i +: 4] & {4{digit_idx_q == 3'(i)}});
            dp_s     = dp_s | (src_dp_s[i] & (digit_idx_q == 3'(i)));
        end
    end

    seg7_hex_decoder u_hex_decoder (
        .nibble (nibble_s),
        .seg    (hex_seg_s)
    );

`ifdef SEG7_LZ_BLANK_EN
    logic [2:0] msnz_s;

    // Locate the most significant non-zero nibble; digits above it are blanked.
    always_comb begin
        msnz_s = 3'd0;
        for (int i = 0; i < DIGITS; i++) begin
            msnz_s = (src_value_s[4*i +: 4] != 4'h0) ? 3'(i) : msnz_s;
        end
        seg_s = (digit_idx_q > msnz_s) ? SEG_BLANK : hex_seg_s;
    end
`else
    // Every digit is shown, leading zeros included.
    always_comb begin
        seg_s = hex_seg_s;
    end
`endif

    // Assemble {dp, segments, digit select}; dp is active-low like the segments.
    always_comb begin
        sel_s         = digit_onehot(digit_idx_q) & SEL_MASK;
        frame_build_s = {~dp_s, seg_s, sel_s};
    end

    // Scan FSM: next state, snapshot, frame and handshake pulses.
    always_comb begin
        state_d        = state_q;
        digit_idx_d    = digit_idx_q;
        snap_value_d   = snap_value_q;
        snap_dp_d      = snap_dp_q;
        frame_d        = frame_q;
        start_d        = 1'b0;
        scan_wrap_d    = 1'b0;
        ack_cnt_d      = ack_cnt_q;
        tick_pending_d = tick_pending_q | tick_s;

        case (state_q)
            ST_BUILD: begin
                if (digit_idx_q == 3'd0) begin
                    snap_value_d = value;
                    snap_dp_d    = dp_mask;
                end else begin
                    snap_value_d = snap_value_q;
                    snap_dp_d    = snap_dp_q;
                end
                frame_d = frame_build_s;
                start_d = 1'b1;
                state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                ack_cnt_d = '0;
                state_d   = ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
                if (busy) begin
                    state_d = ST_WAIT_DONE;
                end else if (ack_cnt_q == AW'(ACK_TIMEOUT - 1)) begin
                    start_d = 1'b1;
                    state_d = ST_ISSUE;
                end else begin
                    ack_cnt_d = ack_cnt_q + AW'(1);
                end
            end
            ST_WAIT_DONE: begin
                if (!busy) begin
                    state_d = ST_DWELL;
                end else begin
                    state_d = ST_WAIT_DONE;
                end
            end
            ST_DWELL: begin
                if (tick_pending_q) begin
                    // A tick landing on this very cycle belongs to the next digit.
                    tick_pending_d = tick_s;
                    if (digit_idx_q == 3'(DIGITS - 1)) begin
                        digit_idx_d = 3'd0;
                        scan_wrap_d = 1'b1;
                    end else begin
                        digit_idx_d = digit_idx_q + 3'd1;
                    end
                    state_d = ST_BUILD;
                end else begin
                    state_d = ST_DWELL;
                end
            end
            default: begin
                state_d = ST_BUILD;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_BUILD;
            digit_idx_q    <= 3'd0;
            snap_value_q   <= '0;
            snap_dp_q      <= '0;
            frame_q        <= FRAME_RESET;
            start_q        <= 1'b0;
            scan_wrap_q    <= 1'b0;
            tick_cnt_q     <= '0;
            tick_pending_q <= 1'b0;
            ack_cnt_q      <= '0;
        end else begin
            state_q        <= state_d;
            digit_idx_q    <= digit_idx_d;
            snap_value_q   <= snap_value_d;
            snap_dp_q      <= snap_dp_d;
            frame_q        <= frame_d;
            start_q        <= start_d;
            scan_wrap_q    <= scan_wrap_d;
            tick_cnt_q     <= tick_cnt_d;
            tick_pending_q <= tick_pending_d;
            ack_cnt_q      <= ack_cnt_d;
        end
    end

    assign start     = start_q;
    assign frame     = frame_q;
    assign digit_idx = digit_idx_q;
    assign scan_wrap = scan_wrap_q;

endmodule

// File: doc/seg7_frame_scanner.md
# seg7_frame_scanner

Multiplexed 7-segment display scanner that feeds the 74HC595 serial shifter stage. Each refresh slot it encodes one hex digit of a snapshotted value into a 16-bit frame, with segment byte high and digit-select byte low. It then hands the frame to the shifter with a start/busy handshake. It sits between the value source (rotary/counter logic) and the shifter, and owns digit timing and frame integrity.

## Interface
- `DIGITS`, 4: number of digits scanned; legal range 1–8.
- `REFRESH_CNT`, 100000: dwell per digit in clk cycles (1 ms at 100 MHz); minimum 2.
- `ACK_TIMEOUT`, 8: cycles to wait for shifter `busy` to rise before re-issuing `start`.
- `clk` in 1: single system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `value` in 4*DIGITS: hex nibbles; digit 0 is `value[3:0]`.
- `dp_mask` in DIGITS: decimal point enable per digit; 1 = dp lit.
- `busy` in 1: from shifter; high while a frame is shifting or latching.
- `start` out 1: one-cycle request pulse to the shifter.
- `frame` out 16: `[15:8]` = segments {dp,g,f,e,d,c,b,a}, active-low (0 = lit); `[7:0]` = one-hot digit select, active-high, bits ≥ DIGITS always 0.
- `digit_idx` out 3: digit currently presented.
- `scan_wrap` out 1: one-cycle pulse when digit_idx wraps to 0.

## Operation
- FSM states: BUILD, ISSUE, WAIT_ACK, WAIT_DONE, DWELL.
- BUILD (1 cycle):
  - If `digit_idx == 0`, capture `value` and `dp_mask` into the snapshot. The frame for this cycle uses the live inputs, which equal the captured data.
  - Register `frame` from the snapshot nibble via the hex decoder, plus the dp bit and the one-hot select.
  - Go to ISSUE.
- ISSUE (1 cycle): `start=1`; clear the ack timer; go to WAIT_ACK.
- WAIT_ACK:
  - If `busy==1`, go to WAIT_DONE.
  - Else, when the ack timer reaches ACK_TIMEOUT-1, go to ISSUE (re-issue the same frame).
- WAIT_DONE: when `busy==0`, go to DWELL.
- DWELL:
  - When `tick_pending`, clear it and advance `digit_idx`. The increment wraps DIGITS-1 → 0, and `scan_wrap` pulses on wrap.
  - Go to BUILD.
- Tick counter: free-running 0..REFRESH_CNT-1. At terminal count it sets `tick_pending`, in any state.
  - A tick arriving during a shift is held, so the next digit starts immediately after DWELL is entered.
  - Multiple ticks collapse into one.
- `frame` is stable from BUILD exit until the next BUILD. The shifter samples it one cycle after `start`, which is guaranteed.
- Value changes mid-scan affect only the next scan; digits within one scan never tear.

## Timing
- Reset values:
  - `start=0`, `frame=16'hFF00` (all off), `digit_idx=0`, `scan_wrap=0`.
  - Snapshot = 0, tick counter = 0, `tick_pending=0`, state = BUILD.
- First `start` occurs 1 cycle after reset release (BUILD at cycle 0, ISSUE at cycle 1).
- From `busy` falling to the next `start`:
  - 3 cycles if a tick is pending (DWELL, BUILD, ISSUE).
  - Otherwise, wait for the tick.
- If `busy` is already high in ISSUE (shifter stuck), WAIT_ACK exits on the first cycle.
- Reset mid-shift returns to reset values immediately; the shifter is reset independently.
- `start` is never asserted while in WAIT_ACK, WAIT_DONE or DWELL.

## Configuration
- `SEG7_LZ_BLANK_EN` defined: leading-zero blanking.
  - Digits above the most significant non-zero nibble of the snapshot show segments off (`frame[14:8]=7'h7F`).
  - Digit 0 is always displayed.
  - The dp bit still follows `dp_mask`.
- `SEG7_LZ_BLANK_EN` undefined: every digit is displayed, including leading zeros. The blanking logic is absent.

## Structure
- Package `seg7_pkg` holds:
  - FSM state encoding constants.
  - Frame field positions (SEG_MSB=15, SEG_LSB=8, SEL_MSB=7, SEL_LSB=0).
  - The 16-entry active-low hex segment table (0→7'h40, 1→7'h79, …, F→7'h0E, bit order {g..a}).
  - Blank code 7'h7F.
- Sub-module `seg7_hex_decoder`: combinational nibble→7-bit segments lookup, instanced once.

## Test plan
Benches use REFRESH_CNT=20 and a behavioural shifter (busy rises 2 cycles after start and lasts 10 cycles).
- Reset release with `value=16'h1234`, `dp_mask=0`:
  - First `start` at cycle 1 with `frame=16'h9901` (digit 0 = "4").
  - Next frames are `16'hB002`, `16'hA404`, `16'hF908`.
  - `scan_wrap` pulses once per 4 digits.
- `dp_mask=4'b0010`, `value=16'h0000`: the digit 1 frame is `16'h4002` (dp lit, "0"). With `SEG7_LZ_BLANK_EN` defined:
  - Digits 1–3 segments read 7'h7F, so digit 1 shows dp only.
  - Digit 0 shows "0".
- Change `value` from `16'h1234` to `16'h5678` while digit 2 is shifting:
  - Digits 2–3 still show 2, 1.
  - New digits appear only from the next wrap.
- Shifter model ignores the first `start`: `start` re-issues after exactly ACK_TIMEOUT cycles with an identical `frame`, and scanning continues normally.
- Shift longer than REFRESH_CNT (busy = 30 cycles): the next `start` comes 3 cycles after busy falls, and no digit is skipped.
- Assert `rst_n=0` during WAIT_DONE: outputs return to reset values asynchronously, and the scan restarts at digit 0 after release.
